// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with post-reset hardware clear sweep.
// Optional REG_FILE_ZERO_REG_EN hardwires entry 0 to zero.
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     wr_drop
);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic wr_ok;
  assign busy = state == CLEAR;
  assign wr_ok = we && !busy && !(ZERO_REG && wr_addr == '0);
  always_comb begin
    state_next = rst ? CLEAR : (busy && clr_ptr == '1) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    state   <= state_next;
    clr_ptr <= rst ? '0 : busy ? clr_ptr + 1'b1 : clr_ptr;
    wr_drop <= !rst && we && busy;
  end
  // the reset edge itself leaves the array alone; the sweep does the zeroing
  always_ff @(posedge clk) begin
    if (!rst && busy) mem[clr_ptr] <= '0;
    else if (!rst && wr_ok) mem[wr_addr] <= wr_data;
  end
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] =
        (busy || (ZERO_REG && rd_addr[i*ADDR_W +: ADDR_W] == '0)) ? '0 :
        (we && wr_addr == rd_addr[i*ADDR_W +: ADDR_W]) ? wr_data :
        mem[rd_addr[i*ADDR_W +: ADDR_W]];
    end
  end
endmodule
